// File: rtl/morse_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : morse_pkg
//  Description : Shared types and constants for the Morse framing front end:
//                framer state encoding, pattern width and gap thresholds
//                (measured in Morse units / samples).
//  Revision    : 1.0 - initial release
// ============================================================================
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        GAP     = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    localparam int         CODE_W      = 24;
    localparam logic [2:0] LETTER_GAP  = 3'd3;
    localparam logic [2:0] WORD_GAP    = 3'd7;
    localparam logic [4:0] MAX_SAMPLES = 5'd24;

endpackage
`default_nettype wire

// File: rtl/morse_unit_timer.sv
`default_nettype none
// ============================================================================
//  Module      : morse_unit_timer
//  Description : Morse unit prescaler. A restart places the first tick half a
//                unit later so the key is sampled mid-unit; afterwards a tick
//                fires every UNIT_CYCLES while run_i is high. Holds when
//                run_i is low.
//  Ports       : clk, rst       - clock, async active-high reset
//                restart_i      - reload for a half-unit first period
//                run_i          - count enable
//                tick_o         - one-cycle sample strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module morse_unit_timer #(
    parameter int UNIT_CYCLES = 3_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart_i,
    input  logic run_i,
    output logic tick_o
);

    localparam int             CNT_W     = $clog2(UNIT_CYCLES);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(UNIT_CYCLES / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(UNIT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = HALF_LOAD;
        end else if (run_i) begin
            cnt_d = (cnt_q == '0) ? FULL_LOAD : cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = run_i && (cnt_q == '0) && !restart_i;

endmodule
`default_nettype wire

// File: rtl/morse_framer.sv
`default_nettype none
// ============================================================================
//  Module      : morse_framer
//  Description : Samples a keyed Morse line once per unit and frames letters
//                into right-aligned element patterns (1 = tone, one trailing
//                0). A 3-unit silence strobes the letter, a 7-unit silence
//                strobes pattern 0 (space). Letters longer than CODE_W
//                samples are discarded with a one-cycle ovf_o pulse.
//  Ports       : clk, rst       - clock, async active-high reset
//                en_i           - synchronous enable
//                key_i          - raw asynchronous Morse line
//                code_o         - last framed pattern
//                code_vld_o     - one-cycle strobe for code_o
//                ovf_o          - one-cycle overflow pulse
//                busy_o         - framer not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module morse_framer #(
    parameter int UNIT_CYCLES = 3_000_000,
    parameter int CODE_W      = morse_pkg::CODE_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              key_i,
    output logic [CODE_W-1:0] code_o,
    output logic              code_vld_o,
    output logic              ovf_o,
    output logic              busy_o
);

    import morse_pkg::*;

    // ------------------------------------------------------------------
    // Key synchroniser. Flops reset high so a key already held down when
    // reset releases is not mistaken for the start of a new letter.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   key_prev_q;
    logic                   key_s;
    logic                   rise;

    generate
        if (SYNC_STAGES == 1) begin : g_sync_one
            always_ff @(posedge clk or posedge rst) begin
                if (rst) sync_q <= '1;
                else     sync_q <= key_i;
            end
        end else begin : g_sync_multi
            always_ff @(posedge clk or posedge rst) begin
                if (rst) sync_q <= '1;
                else     sync_q <= {sync_q[SYNC_STAGES-2:0], key_i};
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) key_prev_q <= 1'b1;
        else     key_prev_q <= key_s;
    end

    assign key_s = sync_q[SYNC_STAGES-1];
    assign rise  = key_s && !key_prev_q;

    // ------------------------------------------------------------------
    // Unit timer: restarted on the edge that opens a letter, runs while
    // the framer is active.
    // ------------------------------------------------------------------
    state_t state_q, state_d;
    logic   tick;

    morse_unit_timer #(
        .UNIT_CYCLES (UNIT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .restart_i (state_q == IDLE && rise),
        .run_i     (state_q != IDLE),
        .tick_o    (tick)
    );

    // ------------------------------------------------------------------
    // Framing FSM
    // ------------------------------------------------------------------
    logic [CODE_W-1:0] sh_q, sh_d, sh_n;
    logic [4:0]        nbits_q, nbits_d, nbits_n;
    logic [2:0]        zrun_q, zrun_d, zrun_n;
    logic [CODE_W-1:0] code_q, code_d;
    logic              vld_q, vld_d;
    logic              ovf_q, ovf_d;

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        nbits_d = nbits_q;
        zrun_d  = zrun_q;
        code_d  = code_q;
        vld_d   = 1'b0;
        ovf_d   = 1'b0;
        sh_n    = {sh_q[CODE_W-2:0], key_s};
        nbits_n = nbits_q + 5'd1;
        zrun_n  = key_s ? 3'd0 : zrun_q + 3'd1;

        if (!en_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        sh_d    = '0;
                        nbits_d = 5'd0;
                        zrun_d  = 3'd0;
                        state_d = COLLECT;
                    end
                end
                COLLECT: begin
                    if (tick) begin
                        sh_d    = sh_n;
                        nbits_d = nbits_n;
                        zrun_d  = zrun_n;
                        if (zrun_n == LETTER_GAP) begin
                            // Drop two of the three gap zeros, keep one as
                            // the letter terminator.
                            code_d  = sh_n >> 2;
                            vld_d   = 1'b1;
                            state_d = GAP;
                        end else if (nbits_n == MAX_SAMPLES) begin
                            ovf_d   = 1'b1;
                            state_d = DRAIN;
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (key_s) begin
                            // Tone during a gap opens the next letter; this
                            // sample is its first element unit.
                            sh_d    = {{(CODE_W-1){1'b0}}, 1'b1};
                            nbits_d = 5'd1;
                            zrun_d  = 3'd0;
                            state_d = COLLECT;
                        end else begin
                            zrun_d = zrun_n;
                            if (zrun_n == WORD_GAP) begin
                                code_d  = '0;
                                vld_d   = 1'b1;
                                state_d = IDLE;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (tick) begin
                        zrun_d = zrun_n;
                        if (zrun_n == LETTER_GAP) begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            nbits_q <= 5'd0;
            zrun_q  <= 3'd0;
            code_q  <= '0;
            vld_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            nbits_q <= nbits_d;
            zrun_q  <= zrun_d;
            code_q  <= code_d;
            vld_q   <= vld_d;
            ovf_q   <= ovf_d;
        end
    end

    assign code_o     = code_q;
    assign code_vld_o = vld_q;
    assign ovf_o      = ovf_q;
    assign busy_o     = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_morse_framer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_morse_framer
//  Description : Self-checking bench for morse_framer with an expected-code
//                scoreboard. Key is driven in whole Morse units (8 clocks).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_morse_framer;

    localparam int UNIT   = 8;
    localparam int CODE_W = 24;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              key;
    logic [CODE_W-1:0] code;
    logic              code_vld;
    logic              ovf;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;
    int vld_cnt  = 0;
    int ovf_cnt  = 0;
    int push_cnt = 0;
    int vld_snap;

    logic [CODE_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    morse_framer #(
        .UNIT_CYCLES (UNIT),
        .CODE_W      (CODE_W),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en_i       (en),
        .key_i      (key),
        .code_o     (code),
        .code_vld_o (code_vld),
        .ovf_o      (ovf),
        .busy_o     (busy)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic push(input logic [CODE_W-1:0] c);
        exp_q.push_back(c);
        push_cnt++;
    endtask

    // One character per Morse unit: '1' = tone, '0' = silence.
    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) begin
            key = (s[i] == 8'h31);
            repeat (UNIT) @(negedge clk);
        end
    endtask

    task automatic hold(input logic v, input int units);
        key = v;
        repeat (units * UNIT) @(negedge clk);
    endtask

    // Scoreboard: every strobe must match the oldest expected pattern.
    always @(negedge clk) begin
        if (!rst) begin
            if (code_vld) begin
                vld_cnt++;
                if (exp_q.size() == 0)
                    check("unexpected_vld", exp_q.size(), 1);
                else
                    check("code", code, exp_q.pop_front());
            end
            if (ovf) begin
                ovf_cnt++;
                check("ovf_vld_excl", code_vld, 1'b0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        key = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_code", code, 0);
        check("rst_vld", code_vld, 0);
        check("rst_ovf", ovf, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 1: 'E' then word gap
        push(24'h000002);
        push(24'h000000);
        send("10000000000");
        check("e_busy", busy, 0);
        check("e_drain", exp_q.size(), 0);

        // 2: 'A' - exactly one strobe after three gap units
        push(24'h00002E);
        vld_snap = vld_cnt;
        send("10111000");
        check("a_strobes", vld_cnt - vld_snap, 1);
        push(24'h000000);
        send("0000");
        check("a_drain", exp_q.size(), 0);

        // 3: "SOS" then word gap
        push(24'h00002A);
        push(24'h000EEE);
        push(24'h00002A);
        push(24'h000000);
        send("10101000");
        send("11101110111000");
        send("101010000000");
        check("sos_drain", exp_q.size(), 0);

        // 4: digit '0', left in the gap state
        push(24'h0EEEEE);
        send("1110111011101110111000");
        check("d0_ovf", ovf_cnt, 0);
        check("d0_drain", exp_q.size(), 0);

        // 5: overlong tone -> one ovf pulse, no strobe, code retained
        vld_snap = vld_cnt;
        hold(1'b1, 30);
        hold(1'b0, 3);
        check("ovf_pulses", ovf_cnt, 1);
        check("ovf_no_vld", vld_cnt - vld_snap, 0);
        check("ovf_code_kept", code, 32'h0EEEEE);
        check("ovf_busy", busy, 0);
        push(24'h000002);
        push(24'h000000);
        send("10000000");
        check("ovf_e_drain", exp_q.size(), 0);

        // 6a: reset mid-dash
        push(24'h000002);
        send("1000");
        key = 1'b1;
        repeat (UNIT + 4) @(negedge clk);
        vld_snap = vld_cnt;
        rst = 1'b1;
        #1;
        check("arst_code", code, 0);
        check("arst_vld", code_vld, 0);
        check("arst_ovf", ovf, 0);
        check("arst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hold(1'b1, 2);
        hold(1'b0, 10);
        check("arst_no_vld", vld_cnt - vld_snap, 0);
        push(24'h00000E);
        push(24'h000000);
        send("1110000000");
        check("arst_t_drain", exp_q.size(), 0);

        // 6b: enable dropped mid-dash
        push(24'h000002);
        send("1000");
        hold(1'b1, 1);
        vld_snap = vld_cnt;
        en = 1'b0;
        hold(1'b1, 1);
        check("en_busy", busy, 0);
        hold(1'b0, 10);
        check("en_code_kept", code, 32'h000002);
        check("en_no_vld", vld_cnt - vld_snap, 0);
        en = 1'b1;
        repeat (2) @(negedge clk);
        push(24'h00000E);
        push(24'h000000);
        send("1110000000");

        check("final_drain", exp_q.size(), 0);
        check("final_strobes", vld_cnt, push_cnt);
        check("final_ovf", ovf_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
